// File: rtl/afu_copy_engine.sv
// afu_copy_engine
// Core-side copy engine behind the MMIO/CCI-P adapter. On start it reads a
// header line at src to learn the line count N, copies lines src+1..src+N to
// dst+0..dst+N-1 through a local FIFO, then issues a write fence and a
// completion write to the DSM line.
//
// Ports
//   clk, core_reset_n      : clock, synchronous active-low reset
//   core_start             : level start, sampled only in IDLE
//   io_src_ptr/io_dst_ptr  : source / destination cache-line addresses
//   dsm_base_addr          : DSM cache-line address for the completion write
//   tx_rd/wr_almostfull    : request channel backpressure
//   cor_tx_rd_*            : read request (valid pulse, address, length)
//   io_rx_rd_valid/data    : read response
//   cor_tx_wr_* / *_valid  : write request plus fence / done / dsr qualifiers
//   core_busy, core_done   : status
module afu_copy_engine #(
  parameter int unsigned MAX_OUTSTANDING = 1,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic         clk,
  input  logic         core_reset_n,
  input  logic         core_start,
  input  logic [63:0]  io_src_ptr,
  input  logic [63:0]  io_dst_ptr,
  input  logic [63:0]  dsm_base_addr,
  input  logic         tx_rd_almostfull,
  input  logic         tx_wr_almostfull,
  output logic         cor_tx_rd_valid,
  output logic [57:0]  cor_tx_rd_addr,
  output logic [5:0]   cor_tx_rd_len,
  input  logic         io_rx_rd_valid,
  input  logic [511:0] io_rx_data,
  output logic         cor_tx_wr_valid,
  output logic         cor_tx_dsr_valid,
  output logic         cor_tx_fence_valid,
  output logic         cor_tx_done_valid,
  output logic [57:0]  cor_tx_wr_addr,
  output logic [5:0]   cor_tx_wr_len,
  output logic [511:0] cor_tx_data,
  output logic         core_busy,
  output logic         core_done
);

  localparam int unsigned AW    = 58;
  localparam int unsigned DW    = 512;
  localparam int unsigned NW    = 32;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_RD,
    ST_HDR_WAIT,
    ST_COPY,
    ST_FENCE,
    ST_DONE_WR,
    ST_COMPLETE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     src_q, src_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [AW-1:0]     dsm_q, dsm_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [NW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  fifo_wptr_q, fifo_wptr_d;
  logic [PTR_W-1:0]  fifo_rptr_q, fifo_rptr_d;
  logic [DW-1:0]     fifo_mem_q [FIFO_DEPTH];

  logic              rd_valid_q, rd_valid_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [5:0]        len_q, len_d;
  logic              wr_valid_q, wr_valid_d;
  logic              dsr_q, dsr_d;
  logic              fence_q, fence_d;
  logic              done_v_q, done_v_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rd_issue_c;
  logic              rsp_dec_c;
  logic              fifo_push_c;
  logic              fifo_pop_c;
  logic              credit_ok_c;
  logic              unused_ptr_hi;

  assign unused_ptr_hi = ^{io_src_ptr[63:58], io_dst_ptr[63:58], dsm_base_addr[63:58]};

  // Room for one more line counting both in-flight reads and buffered lines.
  assign credit_ok_c = (SUM_W'(out_cnt_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(FIFO_DEPTH);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    dsm_d       = dsm_q;
    n_d         = n_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = '0;
    len_d       = 6'h1;
    wr_valid_d  = 1'b0;
    dsr_d       = 1'b0;
    fence_d     = 1'b0;
    done_v_d    = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    rd_issue_c  = 1'b0;
    rsp_dec_c   = 1'b0;
    fifo_push_c = 1'b0;
    fifo_pop_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core_start) begin
          src_d    = io_src_ptr[AW-1:0];
          dst_d    = io_dst_ptr[AW-1:0];
          dsm_d    = dsm_base_addr[AW-1:0];
          n_d      = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = ST_HDR_RD;
        end
      end

      ST_HDR_RD: begin
        if (!tx_rd_almostfull) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = src_q;
          state_d    = ST_HDR_WAIT;
        end
      end

      // Header line only carries N; it never enters the FIFO.
      ST_HDR_WAIT: begin
        if (io_rx_rd_valid) begin
          n_d     = io_rx_data[NW-1:0];
          state_d = (io_rx_data[NW-1:0] == '0) ? ST_FENCE : ST_COPY;
        end
      end

      ST_COPY: begin
        if (wr_cnt_q == n_q) begin
          state_d = ST_FENCE;
        end else begin
          rd_issue_c = (rd_cnt_q < n_q) && (NW'(out_cnt_q) < MAX_OUTSTANDING) &&
                       credit_ok_c && !tx_rd_almostfull;
          if (rd_issue_c) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = src_q + AW'(rd_cnt_q) + AW'(1);
            rd_cnt_d   = rd_cnt_q + NW'(1);
          end
          // Full-FIFO guard only matters for stray responses; credits prevent it otherwise.
          if (io_rx_rd_valid && (fifo_cnt_q != CNT_W'(FIFO_DEPTH))) begin
            fifo_push_c = 1'b1;
            rsp_dec_c   = (out_cnt_q != '0);
          end
          if ((fifo_cnt_q != '0) && !tx_wr_almostfull) begin
            fifo_pop_c = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = dst_q + AW'(wr_cnt_q);
            wr_data_d  = fifo_mem_q[fifo_rptr_q];
            wr_cnt_d   = wr_cnt_q + NW'(1);
          end
        end
      end

      ST_FENCE: begin
        if (!tx_wr_almostfull) begin
          wr_valid_d = 1'b1;
          fence_d    = 1'b1;
          state_d    = ST_DONE_WR;
        end
      end

      ST_DONE_WR: begin
        if (!tx_wr_almostfull) begin
          wr_valid_d         = 1'b1;
          done_v_d           = 1'b1;
          dsr_d              = 1'b1;
          wr_addr_d          = dsm_q;
          wr_data_d[NW-1:0]  = n_q;
          wr_data_d[NW]      = 1'b1;
          state_d            = ST_COMPLETE;
        end
      end

      ST_COMPLETE: begin
        if (!core_start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_cnt_d   = out_cnt_q + CNT_W'(rd_issue_c) - CNT_W'(rsp_dec_c);
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
    fifo_wptr_d = fifo_push_c ? fifo_wptr_q + PTR_W'(1) : fifo_wptr_q;
    fifo_rptr_d = fifo_pop_c ? fifo_rptr_q + PTR_W'(1) : fifo_rptr_q;

    busy_d = (state_d != ST_IDLE) && (state_d != ST_COMPLETE);
    done_d = (state_d == ST_COMPLETE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!core_reset_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      dsm_q       <= '0;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      out_cnt_q   <= '0;
      fifo_cnt_q  <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      len_q       <= '0;
      wr_valid_q  <= 1'b0;
      dsr_q       <= 1'b0;
      fence_q     <= 1'b0;
      done_v_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      dsm_q       <= dsm_d;
      n_q         <= n_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      out_cnt_q   <= out_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      wr_valid_q  <= wr_valid_d;
      dsr_q       <= dsr_d;
      fence_q     <= fence_d;
      done_v_q    <= done_v_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Line storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_push_c) begin
      fifo_mem_q[fifo_wptr_q] <= io_rx_data;
    end
  end

  assign cor_tx_rd_valid    = rd_valid_q;
  assign cor_tx_rd_addr     = rd_addr_q;
  assign cor_tx_rd_len      = len_q;
  assign cor_tx_wr_valid    = wr_valid_q;
  assign cor_tx_dsr_valid   = dsr_q;
  assign cor_tx_fence_valid = fence_q;
  assign cor_tx_done_valid  = done_v_q;
  assign cor_tx_wr_addr     = wr_addr_q;
  assign cor_tx_wr_len      = len_q;
  assign cor_tx_data        = wr_data_q;
  assign core_busy          = busy_q;
  assign core_done          = done_q;

endmodule

// File: tb/tb_afu_copy_engine.sv
// Bench for afu_copy_engine: two instances (MAX_OUTSTANDING 1 and 4, FIFO 8)
// share stimulus; each has its own in-order host-memory responder and
// read/write scoreboards. A vector table drives whole copy operations; a
// hand-written sequence covers reset in the middle of a copy.
module tb_afu_copy_engine;

  localparam int unsigned NI    = 2;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [57:0] src;
    logic [57:0] dst;
    logic [57:0] dsm;
    int          n;
    bit          rd_toggle;
    int          wr_hold;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  typedef struct packed {
    logic [57:0] addr;
    logic [31:0] due;
  } pend_t;

  typedef struct packed {
    logic [57:0]  addr;
    logic [511:0] data;
    logic         fence;
    logic         done;
  } wr_exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [63:0]  src_ptr, dst_ptr, dsm_ptr;
  logic         rd_af, wr_af;

  logic         rd_valid [NI];
  logic [57:0]  rd_addr  [NI];
  logic [5:0]   rd_len   [NI];
  logic         rx_valid [NI];
  logic [511:0] rx_data  [NI];
  logic         wr_valid [NI];
  logic         dsr_v    [NI];
  logic         fence_v  [NI];
  logic         done_v   [NI];
  logic [57:0]  wr_addr  [NI];
  logic [5:0]   wr_len   [NI];
  logic [511:0] wr_data  [NI];
  logic         busy     [NI];
  logic         cdone    [NI];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    afu_copy_engine #(
      .MAX_OUTSTANDING((g == 0) ? 1 : 4),
      .FIFO_DEPTH     (DEPTH)
    ) u_dut (
      .clk               (clk),
      .core_reset_n      (rst_n),
      .core_start        (start),
      .io_src_ptr        (src_ptr),
      .io_dst_ptr        (dst_ptr),
      .dsm_base_addr     (dsm_ptr),
      .tx_rd_almostfull  (rd_af),
      .tx_wr_almostfull  (wr_af),
      .cor_tx_rd_valid   (rd_valid[g]),
      .cor_tx_rd_addr    (rd_addr[g]),
      .cor_tx_rd_len     (rd_len[g]),
      .io_rx_rd_valid    (rx_valid[g]),
      .io_rx_data        (rx_data[g]),
      .cor_tx_wr_valid   (wr_valid[g]),
      .cor_tx_dsr_valid  (dsr_v[g]),
      .cor_tx_fence_valid(fence_v[g]),
      .cor_tx_done_valid (done_v[g]),
      .cor_tx_wr_addr    (wr_addr[g]),
      .cor_tx_wr_len     (wr_len[g]),
      .cor_tx_data       (wr_data[g]),
      .core_busy         (busy[g]),
      .core_done         (cdone[g])
    );
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [57:0] hdr_addr = '0;
  logic [31:0] hdr_n    = '0;

  logic [57:0] exp_rd_q [NI][$];
  wr_exp_t     exp_wr_q [NI][$];
  pend_t       pend_q   [NI][$];
  int          rd_seen  [NI];
  int          wr_seen  [NI];
  int          resp_cnt [NI];
  int          occ      [NI];
  int          occ_max  [NI];

  vec_t vecs [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bits(input string name, input int i, input logic [511:0] got,
                            input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL i%0d_%s got=%0h expected=%0h", i, name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int i, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL i%0d_%s got=%0d expected=%0d", i, name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input int i, input logic [63:0] val);
    vectors++;
    miscompares++;
    $display("FAIL i%0d_%s got=%0h expected=none", i, name, val);
  endtask

  // Host memory contents: header line carries N in [31:0], other lines a pattern.
  function automatic logic [511:0] line_of(input logic [57:0] a);
    logic [511:0] d;
    for (int w = 0; w < 8; w++) d[w*64 +: 64] = {6'(w), a} ^ 64'h5A3C_96E1_0F87_D24B;
    if (a == hdr_addr) d[31:0] = hdr_n;
    return d;
  endfunction

  function automatic logic any_out(input int i);
    return |{rd_valid[i], rd_addr[i], rd_len[i], wr_valid[i], dsr_v[i], fence_v[i],
             done_v[i], wr_addr[i], wr_len[i], wr_data[i], busy[i], cdone[i]};
  endfunction

  task automatic clear_tracking();
    for (int i = 0; i < NI; i++) begin
      exp_rd_q[i].delete();
      exp_wr_q[i].delete();
      rd_seen[i]  = 0;
      wr_seen[i]  = 0;
      resp_cnt[i] = 0;
      occ[i]      = 0;
      occ_max[i]  = 0;
    end
  endtask

  // Responder plus read/write monitors, evaluated once per cycle on the falling edge.
  initial begin : monitor
    pend_t       p;
    wr_exp_t     e;
    logic [57:0] ea;
    for (int i = 0; i < NI; i++) begin
      rx_valid[i] = 1'b0;
      rx_data[i]  = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        rx_valid[i] = 1'b0;
        rx_data[i]  = '0;
        if (pend_q[i].size() > 0) begin
          p = pend_q[i][0];
          if (p.due <= 32'(cyc)) begin
            void'(pend_q[i].pop_front());
            rx_valid[i] = 1'b1;
            rx_data[i]  = line_of(p.addr);
            resp_cnt[i]++;
          end
        end
        if (rd_valid[i]) begin
          p.addr = rd_addr[i];
          p.due  = 32'(cyc + 2);
          pend_q[i].push_back(p);
          if (rd_seen[i] > 0) occ[i]++;
          rd_seen[i]++;
          check_bits("rd_len", i, 512'(rd_len[i]), 512'(6'h1));
          if (exp_rd_q[i].size() == 0) fail_now("rd_unexpected", i, 64'(rd_addr[i]));
          else begin
            ea = exp_rd_q[i].pop_front();
            check_bits("rd_addr", i, 512'(rd_addr[i]), 512'(ea));
          end
        end
        if (wr_valid[i]) begin
          wr_seen[i]++;
          if (!fence_v[i] && !done_v[i]) occ[i]--;
          check_bits("wr_len", i, 512'(wr_len[i]), 512'(6'h1));
          if (exp_wr_q[i].size() == 0) fail_now("wr_unexpected", i, 64'(wr_addr[i]));
          else begin
            e = exp_wr_q[i].pop_front();
            check_bits("wr_addr", i, 512'(wr_addr[i]), 512'(e.addr));
            check_bits("wr_data", i, wr_data[i], e.data);
            check_bits("wr_fence", i, 512'(fence_v[i]), 512'(e.fence));
            check_bits("wr_done", i, 512'(done_v[i]), 512'(e.done));
            check_bits("wr_dsr", i, 512'(dsr_v[i]), 512'(e.done));
          end
        end
        if (occ[i] > occ_max[i]) occ_max[i] = occ[i];
      end
    end
  end

  task automatic push_expected(input vec_t v);
    wr_exp_t     e;
    logic [511:0] d;
    for (int i = 0; i < NI; i++) begin
      exp_rd_q[i].push_back(v.src);
      for (int k = 0; k < v.n; k++) begin
        exp_rd_q[i].push_back(v.src + 58'(k) + 58'd1);
        e.addr  = v.dst + 58'(k);
        e.data  = line_of(v.src + 58'(k) + 58'd1);
        e.fence = 1'b0;
        e.done  = 1'b0;
        exp_wr_q[i].push_back(e);
      end
      e.addr  = '0;
      e.data  = '0;
      e.fence = 1'b1;
      e.done  = 1'b0;
      exp_wr_q[i].push_back(e);
      d       = '0;
      d[31:0] = 32'(v.n);
      d[32]   = 1'b1;
      e.addr  = v.dsm;
      e.data  = d;
      e.fence = 1'b0;
      e.done  = 1'b1;
      exp_wr_q[i].push_back(e);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int t;
    clear_tracking();
    hdr_addr = v.src;
    hdr_n    = 32'(v.n);
    push_expected(v);
    src_ptr = {6'h15, v.src};
    dst_ptr = {6'h2A, v.dst};
    dsm_ptr = {6'h3F, v.dsm};
    rd_af   = 1'b0;
    wr_af   = (v.wr_hold > 0);
    start   = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      check_bits($sformatf("v%0d_busy_after_start", idx), i, 512'(busy[i]), 512'(1'b1));
      check_bits($sformatf("v%0d_no_early_rd", idx), i, 512'(rd_valid[i]), 512'(1'b0));
    end
    t = 1;
    if (!v.rd_toggle) begin
      @(negedge clk); #1;
      t = 2;
      for (int i = 0; i < NI; i++)
        check_bits($sformatf("v%0d_hdr_rd_timing", idx), i, 512'(rd_valid[i]), 512'(1'b1));
    end
    while (!(cdone[0] && cdone[1]) && t < 3000) begin
      if (v.rd_toggle) rd_af = ~rd_af;
      wr_af = (t < v.wr_hold);
      @(negedge clk); #1;
      t++;
    end
    if (t >= 3000) fail_now($sformatf("v%0d_timeout", idx), 0, 64'(t));
    for (int i = 0; i < NI; i++) begin
      check_bits($sformatf("v%0d_done", idx), i, 512'(cdone[i]), 512'(1'b1));
      check_bits($sformatf("v%0d_busy_in_complete", idx), i, 512'(busy[i]), 512'(1'b0));
      check_int($sformatf("v%0d_read_count", idx), i, rd_seen[i], v.exp_reads);
      check_int($sformatf("v%0d_write_count", idx), i, wr_seen[i], v.exp_writes);
      check_int($sformatf("v%0d_reads_left", idx), i, exp_rd_q[i].size(), 0);
      check_int($sformatf("v%0d_writes_left", idx), i, exp_wr_q[i].size(), 0);
      check_int($sformatf("v%0d_occ_le_depth", idx), i, (occ_max[i] <= int'(DEPTH)) ? 1 : 0, 1);
    end
    if (v.wr_hold > 0)
      check_int($sformatf("v%0d_credit_fills_fifo", idx), 1, occ_max[1], int'(DEPTH));
    rd_af = 1'b0;
    wr_af = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      check_bits($sformatf("v%0d_done_cleared", idx), i, 512'(cdone[i]), 512'(1'b0));
      check_bits($sformatf("v%0d_idle_not_busy", idx), i, 512'(busy[i]), 512'(1'b0));
    end
  endtask

  task automatic reset_mid_copy();
    int   t;
    vec_t v;
    clear_tracking();
    v = '{src: 58'h7000, dst: 58'hA000, dsm: 58'hB000, n: 10, rd_toggle: 1'b0,
          wr_hold: 0, exp_reads: 0, exp_writes: 0};
    hdr_addr = v.src;
    hdr_n    = 32'(v.n);
    push_expected(v);
    src_ptr = {6'h0, v.src};
    dst_ptr = {6'h0, v.dst};
    dsm_ptr = {6'h0, v.dsm};
    rd_af   = 1'b0;
    wr_af   = 1'b1;
    start   = 1'b1;
    t = 0;
    while (!(resp_cnt[1] >= 1 && (rd_seen[1] - resp_cnt[1]) >= 2) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 200) fail_now("rst_wait_outstanding", 1, 64'(t));
    rst_n = 1'b0;
    start = 1'b0;
    clear_tracking();
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++)
      check_bits("rst_mid_outputs_zero", i, 512'(any_out(i)), 512'(1'b0));
    rst_n = 1'b1;
    wr_af = 1'b0;
    repeat (15) begin
      @(negedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      check_int("rst_stale_no_reads", i, rd_seen[i], 0);
      check_int("rst_stale_no_writes", i, wr_seen[i], 0);
      check_bits("rst_stale_idle", i, 512'(busy[i]), 512'(1'b0));
    end
    t = 0;
    while ((pend_q[0].size() > 0 || pend_q[1].size() > 0) && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 100) fail_now("rst_drain_timeout", 0, 64'(t));
  endtask

  initial begin : main
    vecs[0] = '{src: 58'h100, dst: 58'h200, dsm: 58'h300, n: 4, rd_toggle: 1'b0,
                wr_hold: 0, exp_reads: 5, exp_writes: 6};
    vecs[1] = '{src: 58'h500, dst: 58'h600, dsm: 58'h700, n: 0, rd_toggle: 1'b0,
                wr_hold: 0, exp_reads: 1, exp_writes: 2};
    vecs[2] = '{src: 58'h1000, dst: 58'h2000, dsm: 58'h3000, n: 20, rd_toggle: 1'b0,
                wr_hold: 30, exp_reads: 21, exp_writes: 22};
    vecs[3] = '{src: 58'h4000, dst: 58'h5000, dsm: 58'h6000, n: 6, rd_toggle: 1'b1,
                wr_hold: 0, exp_reads: 7, exp_writes: 8};
    vecs[4] = '{src: 58'h3FF_FFFF_FFFF_FFFE, dst: 58'h3FF_FFFF_FFFF_FFFF, dsm: 58'h9000,
                n: 3, rd_toggle: 1'b0, wr_hold: 0, exp_reads: 4, exp_writes: 5};

    clear_tracking();
    rst_n   = 1'b0;
    start   = 1'b0;
    src_ptr = '0;
    dst_ptr = '0;
    dsm_ptr = '0;
    rd_af   = 1'b0;
    wr_af   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      check_bits("reset_outputs_zero", i, 512'(any_out(i)), 512'(1'b0));
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      check_bits("rd_len_after_reset", i, 512'(rd_len[i]), 512'(6'h1));
      check_bits("wr_len_after_reset", i, 512'(wr_len[i]), 512'(6'h1));
      check_bits("idle_busy", i, 512'(busy[i]), 512'(1'b0));
      check_bits("idle_done", i, 512'(cdone[i]), 512'(1'b0));
    end

    for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);
    reset_mid_copy();
    run_vec(5, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/afu_copy_engine.md
# afu_copy_engine

Core-side stage directly downstream of the MMIO/CCI-P adapter (`afu_io`). After software writes the source, destination and DSM pointers and sets start, it fetches a header line from the source buffer to learn the line count N. It then copies N cache lines from `src+1..src+N` to `dst+0..dst+N-1` through a local FIFO. When the copy finishes it issues a write fence, then writes a completion line to the DSM.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 1: maximum number of read requests in flight (1..FIFO_DEPTH). Values above 1 are legal only on platforms that return read responses in request order.
- `FIFO_DEPTH`, 8: depth of the data FIFO in cache lines; must be a power of two, minimum 2.

Ports:
- `clk` in 1: sole clock.
- `core_reset_n` in 1: reset, synchronous and active-low.
- `core_start` in 1: level; sampled only in IDLE.
- `io_src_ptr` in 64: source cache-line address; bits [57:0] used.
- `io_dst_ptr` in 64: destination cache-line address; bits [57:0] used.
- `dsm_base_addr` in 64: DSM cache-line address; bits [57:0] used.
- `tx_rd_almostfull` in 1: read request channel backpressure.
- `tx_wr_almostfull` in 1: write request channel backpressure.
- `cor_tx_rd_valid` out 1: one-cycle read request pulse.
- `cor_tx_rd_addr` out 58: read cache-line address.
- `cor_tx_rd_len` out 6: always 6'h1.
- `io_rx_rd_valid` in 1: read response valid.
- `io_rx_data` in 512: read response data.
- `cor_tx_wr_valid` out 1: one-cycle write request pulse.
- `cor_tx_dsr_valid` out 1: qualifier asserted with the done write.
- `cor_tx_fence_valid` out 1: qualifier marking a fence.
- `cor_tx_done_valid` out 1: qualifier marking the done write.
- `cor_tx_wr_addr` out 58: write cache-line address.
- `cor_tx_wr_len` out 6: always 6'h1.
- `cor_tx_data` out 512: write data.
- `core_busy` out 1: high in every state except IDLE and COMPLETE.
- `core_done` out 1: high in COMPLETE.

## Operation
- Every output is registered. While `core_reset_n`=0, every output is 0, the FSM is in IDLE, and all counters and FIFO pointers are 0. `cor_tx_rd_len` and `cor_tx_wr_len` read 0 during reset and 6'h1 afterwards.
- FSM: IDLE → HDR_RD → HDR_WAIT → COPY → FENCE → DONE_WR → COMPLETE → IDLE.
- IDLE: when `core_start`=1, latch src, dst and dsm (bits [57:0]), then go to HDR_RD.
- HDR_RD: when `tx_rd_almostfull`=0, issue a read of `src`, then go to HDR_WAIT.
- HDR_WAIT: on `io_rx_rd_valid`, latch N = `io_rx_data[31:0]`. The header line is not pushed to the FIFO. If N=0 go to FENCE, otherwise go to COPY.
- COPY, read side: issue a read of `src+1+rd_cnt` when all of the following hold:
  - rd_cnt < N;
  - outstanding < MAX_OUTSTANDING;
  - outstanding + fifo_count < FIFO_DEPTH;
  - `tx_rd_almostfull`=0.
  - Each issued read increments rd_cnt and outstanding.
- COPY, response side: each `io_rx_rd_valid` pushes `io_rx_data` into the FIFO and decrements outstanding. The credit rule above guarantees the FIFO never overflows.
- COPY, write side: when the FIFO is non-empty and `tx_wr_almostfull`=0, pop the FIFO head and issue a write to `dst+wr_cnt`, then increment wr_cnt. Fence and done qualifiers are 0 on these writes.
- COPY exit: when wr_cnt = N, go to FENCE.
- Concurrency: in one cycle a read issue, a response push and a write pop may all occur. Outstanding and fifo_count each update by their net change.
- FENCE: when `tx_wr_almostfull`=0, pulse `cor_tx_wr_valid` and `cor_tx_fence_valid` with address 0 and data 0, then go to DONE_WR.
- DONE_WR: when `tx_wr_almostfull`=0, pulse `cor_tx_wr_valid`, `cor_tx_done_valid` and `cor_tx_dsr_valid` with address = dsm. Data: [31:0]=N, [32]=1, all other bits 0. Then go to COMPLETE.
- COMPLETE: hold `core_done`=1 until `core_start`=0, then go to IDLE.
- Address arithmetic is modulo 2^58; a wrap past all-ones continues at 0. Counters are 32 bits wide.
- `io_rx_rd_valid` is ignored outside HDR_WAIT and COPY. This drops stale responses that arrive after a reset.
- Deasserting `core_start` mid-operation has no effect. Only `core_reset_n` aborts an operation.
- Reset mid-operation returns the block to the reset state on the next edge. Requests already sent are not tracked.

## Timing
- The cycle after `core_start` is sampled in IDLE: FSM in HDR_RD. The header `cor_tx_rd_valid` pulses one cycle later if `tx_rd_almostfull`=0.
- Header response to first COPY read: 1 cycle (state change), plus 1 cycle for the registered request.
- Response push to earliest write of that line: 1 cycle.
- Throughput with MAX_OUTSTANDING ≥ 2: one read and one write per cycle.
- Almost-full is sampled at the cycle a request would be registered; the request is held off while it is 1. No request is dropped.
- Last copy write to fence: ≥ 1 cycle. Fence to done write: ≥ 1 cycle.
- The done write is the last of all writes in program order.

## Test plan
- N=4, src=0x100, dst=0x200, dsm=0x300, MAX_OUTSTANDING=1:
  - reads go to 0x100..0x104 and writes to 0x200..0x203 with matching data;
  - a fence follows, then a done write to 0x300 with data {..., bit32=1, 0x4};
  - `core_done`=1.
- N=0: only the header read occurs, then the fence, then a done write with data[31:0]=0; no copy writes.
- MAX_OUTSTANDING=4, FIFO_DEPTH=8, N=20, `tx_wr_almostfull` held high for 30 cycles:
  - outstanding + fifo_count never exceeds 8;
  - no data is lost, and the 20 writes appear in order after release.
- `tx_rd_almostfull` toggling every cycle during COPY: the read count is exactly N+1 (header plus N) and the addresses are contiguous.
- src=0x3FF_FFFF_FFFF_FFFE (58-bit), N=3: reads go to ...FFFE (header), ...FFFF, 0x0, 0x1.
- Reset pulled low during COPY with 2 reads outstanding:
  - all outputs are 0 next cycle and the FSM is in IDLE;
  - late `io_rx_rd_valid` pulses are ignored and produce no write.
